// File: rtl/fifo8_addr_ctrl.sv
module fifo8_addr_ctrl #(
  parameter int unsigned AFULL_LVL = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic       flush,
  output logic [2:0] wr_add,
  output logic       wr_en,
  output logic [2:0] rd_add,
  output logic       rd_en,
  output logic [3:0] count,
  output logic       full,
  output logic       empty,
  output logic       almost_full,
  output logic       overflow,
  output logic       underflow
);

  logic [2:0] wr_add_q, wr_add_d;
  logic [2:0] rd_add_q, rd_add_d;
  logic [3:0] count_q, count_d;
  logic       overflow_q, overflow_d;
  logic       underflow_q, underflow_d;

  // Pointers are equal both when empty and when full; only count tells them apart.
  assign full        = (count_q == 4'd8);
  assign empty       = (count_q == 4'd0);
  assign almost_full = (32'(count_q) >= AFULL_LVL);

  assign wr_en = wr_req & ~full  & ~flush & rst_n;
  assign rd_en = rd_req & ~empty & ~flush & rst_n;

  always_comb begin
    wr_add_d    = wr_add_q;
    rd_add_d    = rd_add_q;
    count_d     = count_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (flush) begin
      wr_add_d = '0;
      rd_add_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_add_d = wr_add_q + 3'd1;
      if (rd_en) rd_add_d = rd_add_q + 3'd1;
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + 4'd1;
        2'b01:   count_d = count_q - 4'd1;
        default: count_d = count_q;
      endcase
      overflow_d  = wr_req & full;
      underflow_d = rd_req & empty;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_add_q    <= '0;
      rd_add_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_add_q    <= wr_add_d;
      rd_add_q    <= rd_add_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign wr_add    = wr_add_q;
  assign rd_add    = rd_add_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo8_addr_ctrl.sv
module tb_fifo8_addr_ctrl;

  logic       clk;
  logic       rst_n, wr_req, rd_req, flush;
  logic [2:0] wr_add, rd_add;
  logic       wr_en, rd_en;
  logic [3:0] count;
  logic       full, empty, almost_full, overflow, underflow;

  fifo8_addr_ctrl #(.AFULL_LVL(6)) dut (
    .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .rd_req(rd_req), .flush(flush),
    .wr_add(wr_add), .wr_en(wr_en), .rd_add(rd_add), .rd_en(rd_en),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [16:0] v;
  } exp_t;

  exp_t q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Packed layout: wr_add, rd_add, count, wr_en, rd_en, full, empty, almost_full, overflow, underflow
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      logic [16:0] act;
      e   = q.pop_front();
      act = {wr_add, rd_add, count, wr_en, rd_en, full, empty, almost_full, overflow, underflow};
      n_cmp++;
      if (act !== e.v) begin
        n_bad++;
        $display("FAIL %s: got %b required %b", e.nm, act, e.v);
      end
    end
  end

  task automatic step(input string nm, input logic w, input logic r, input logic f, input logic rn,
                      input logic we, input logic re, input logic [2:0] wa, input logic [2:0] ra,
                      input logic [3:0] cnt, input logic ov, input logic un);
    exp_t e;
    @(posedge clk);
    #1;
    wr_req = w;
    rd_req = r;
    flush  = f;
    rst_n  = rn;
    e.nm = nm;
    e.v  = {wa, ra, cnt, we, re, (cnt == 4'd8), (cnt == 4'd0), (cnt >= 4'd6), ov, un};
    q.push_back(e);
  endtask

  initial begin
    rst_n  = 1'b0;
    wr_req = 1'b0;
    rd_req = 1'b0;
    flush  = 1'b0;
    repeat (2) @(posedge clk);

    step("reset_state", 0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 4'd0, 0, 0);
    step("reset_req_gated", 1, 1, 0, 0, 0, 0, 3'd0, 3'd0, 4'd0, 0, 0);

    for (int i = 0; i < 8; i++)
      step("fill8", 1, 0, 0, 1, 1, 0, 3'(i), 3'd0, 4'(i), 0, 0);

    step("full_wr_rd", 1, 1, 0, 1, 0, 1, 3'd0, 3'd0, 4'd8, 0, 0);
    step("overflow_pulse", 0, 0, 0, 1, 0, 0, 3'd0, 3'd1, 4'd7, 1, 0);
    step("overflow_clear", 0, 0, 0, 1, 0, 0, 3'd0, 3'd1, 4'd7, 0, 0);

    for (int i = 0; i < 4; i++)
      step("drain_to3", 0, 1, 0, 1, 0, 1, 3'd0, 3'(1 + i), 4'(7 - i), 0, 0);

    for (int i = 0; i < 10; i++)
      step("simul_wr_rd", 1, 1, 0, 1, 1, 1, 3'(i), 3'(5 + i), 4'd3, 0, 0);
    step("simul_result", 0, 0, 0, 1, 0, 0, 3'd2, 3'd7, 4'd3, 0, 0);

    for (int i = 0; i < 3; i++)
      step("drain_to0", 0, 1, 0, 1, 0, 1, 3'd2, 3'(7 + i), 4'(3 - i), 0, 0);

    step("rd_empty", 0, 1, 0, 1, 0, 0, 3'd2, 3'd2, 4'd0, 0, 0);
    step("underflow_pulse", 0, 0, 0, 1, 0, 0, 3'd2, 3'd2, 4'd0, 0, 1);
    step("underflow_clear", 0, 0, 0, 1, 0, 0, 3'd2, 3'd2, 4'd0, 0, 0);

    for (int i = 0; i < 5; i++)
      step("fill_to5", 1, 0, 0, 1, 1, 0, 3'(2 + i), 3'd2, 4'(i), 0, 0);

    step("flush_with_wr", 1, 0, 1, 1, 0, 0, 3'd7, 3'd2, 4'd5, 0, 0);
    step("after_flush", 0, 0, 0, 1, 0, 0, 3'd0, 3'd0, 4'd0, 0, 0);
    step("flush_rd_empty", 0, 1, 1, 1, 0, 0, 3'd0, 3'd0, 4'd0, 0, 0);
    step("flush_no_underflow", 0, 0, 0, 1, 0, 0, 3'd0, 3'd0, 4'd0, 0, 0);

    for (int i = 0; i < 6; i++)
      step("fill_to6", 1, 0, 0, 1, 1, 0, 3'(i), 3'd0, 4'(i), 0, 0);

    step("reset_mid", 1, 0, 0, 0, 0, 0, 3'd6, 3'd0, 4'd6, 0, 0);
    step("after_reset", 0, 0, 0, 1, 0, 0, 3'd0, 3'd0, 4'd0, 0, 0);

    for (int i = 0; i < 8; i++)
      step("refill8", 1, 0, 0, 1, 1, 0, 3'(i), 3'd0, 4'(i), 0, 0);
    step("wr_when_full", 1, 0, 0, 1, 0, 0, 3'd0, 3'd0, 4'd8, 0, 0);
    step("wr_when_full2", 1, 0, 0, 1, 0, 0, 3'd0, 3'd0, 4'd8, 1, 0);
    step("ovf_after_2", 0, 0, 0, 1, 0, 0, 3'd0, 3'd0, 4'd8, 1, 0);
    step("ovf_cleared", 1, 0, 1, 0, 0, 0, 3'd0, 3'd0, 4'd8, 0, 0);
    step("reset_over_flush", 0, 0, 0, 1, 0, 0, 3'd0, 3'd0, 4'd0, 0, 0);

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
